// File: rtl/opll_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : opll_bus_pkg
// Description : Shared types and default timing for the OPLL bus write
//               sequencer: FSM state encoding, request record, and the
//               default strobe / wait lengths in clk cycles.
// Revision    : 1.0 - initial release
// ============================================================================
package opll_bus_pkg;

  // Sequencer states; each bus phase is setup / strobe / hold / wait.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_A_SETUP  = 4'd1,
    S_A_STROBE = 4'd2,
    S_A_HOLD   = 4'd3,
    S_A_WAIT   = 4'd4,
    S_D_SETUP  = 4'd5,
    S_D_STROBE = 4'd6,
    S_D_HOLD   = 4'd7,
    S_D_WAIT   = 4'd8
  } state_t;

  localparam int DEF_WR_PULSE  = 2;
  localparam int DEF_ADDR_WAIT = 12;
  localparam int DEF_DATA_WAIT = 84;

  // Chip index is carried at a fixed 8-bit width so the FIFO does not
  // depend on N_CHIPS; out-of-range indices are detected at pop time.
  typedef struct packed {
    logic [7:0] chip;
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/opll_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : opll_wr_fifo
// Description : Synchronous request FIFO with push / pop / flush and an
//               occupancy count. Head entry is visible combinationally.
// Ports       : clk, rst (async, active-high)
//               i_push, i_req   - write strobe and entry
//               i_pop           - consume head entry
//               i_flush         - empty the FIFO; wins over a push
//               o_head          - current head entry
//               o_level         - number of stored entries
//               o_empty         - level == 0
// Revision    : 1.0 - initial release
// ============================================================================
module opll_wr_fifo
  import opll_bus_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  req_t             i_req,
  input  logic             i_pop,
  input  logic             i_flush,
  output req_t             o_head,
  output logic [LVL_W-1:0] o_level,
  output logic             o_empty
);

  req_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full    = (level_q == LVL_W'(DEPTH));
  assign o_empty   = (level_q == '0);
  // A full FIFO may still accept a push when the head leaves the same cycle.
  assign w_do_push = i_push && (!w_full || i_pop) && !i_flush;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = mem_q[rd_ptr_q];
  assign o_level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (w_do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (w_do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      unique case ({w_do_push, w_do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= i_req;
  end

endmodule
`default_nettype wire

// File: rtl/opll_bus_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : opll_bus_write_sequencer
// Description : Queues host (chip, addr, data) writes and replays each as an
//               address-then-data bus cycle on the selected OPLL core, with
//               programmable strobe/wait timing and optional address-phase
//               skipping when the chip's address latch already holds addr.
// Ports       : clk, rst (async, active-high)
//               i_req_valid/o_req_ready, i_req_chip/addr/data - request push
//               i_flush    - drop queued (not in-flight) requests
//               o_CS_n     - per-core chip select, active-low
//               o_WR_n     - shared write strobe, active-low
//               o_A0, o_D  - phase select and data bus
//               o_busy     - sequencer active or requests queued
//               o_level    - FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module opll_bus_write_sequencer
  import opll_bus_pkg::*;
#(
  parameter int N_CHIPS        = 1,
  parameter int FIFO_DEPTH     = 8,
  parameter int WR_PULSE       = DEF_WR_PULSE,
  parameter int ADDR_WAIT      = DEF_ADDR_WAIT,
  parameter int DATA_WAIT      = DEF_DATA_WAIT,
  parameter bit SKIP_SAME_ADDR = 1'b1,
  localparam int CHIP_W = (N_CHIPS > 1) ? $clog2(N_CHIPS) : 1,
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [CHIP_W-1:0]  i_req_chip,
  input  logic [7:0]         i_req_addr,
  input  logic [7:0]         i_req_data,
  input  logic               i_flush,
  output logic [N_CHIPS-1:0] o_CS_n,
  output logic               o_WR_n,
  output logic               o_A0,
  output logic [7:0]         o_D,
  output logic               o_busy,
  output logic [LVL_W-1:0]   o_level
);

  localparam int CNT_MAX    = max3(WR_PULSE, ADDR_WAIT, DATA_WAIT);
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int A_WAIT_LEN = ADDR_WAIT - 2;
  localparam int D_WAIT_LEN = DATA_WAIT - 1;
  // Counter reload values are "cycles remaining minus one".
  localparam logic [CNT_W-1:0] CNT_STROBE = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] CNT_AWAIT  = CNT_W'((A_WAIT_LEN > 0) ? A_WAIT_LEN - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_DWAIT  = CNT_W'((D_WAIT_LEN > 0) ? D_WAIT_LEN - 1 : 0);

  req_t                    w_push_req;
  req_t                    w_head;
  logic                    w_ready;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_empty;
  logic [LVL_W-1:0]        w_level;
  logic [CHIP_W-1:0]       w_head_idx;
  logic                    w_head_ok;
  logic                    w_skip;

  state_t                  state_q;
  logic [CHIP_W-1:0]       cur_idx_q;
  logic [7:0]              cur_addr_q;
  logic [7:0]              cur_data_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [N_CHIPS-1:0]      trk_valid_q;
  logic [N_CHIPS-1:0][7:0] trk_addr_q;
  logic [N_CHIPS-1:0]      cs_n_q;
  logic                    wr_n_q;
  logic                    a0_q;
  logic [7:0]              d_q;

  function automatic logic [N_CHIPS-1:0] sel_n(input logic [CHIP_W-1:0] idx);
    logic [N_CHIPS-1:0] m;
    m      = '1;
    m[idx] = 1'b0;
    return m;
  endfunction

  assign w_ready    = (w_level != LVL_W'(FIFO_DEPTH));
  assign w_push     = i_req_valid && w_ready;
  assign w_push_req = '{chip: 8'(i_req_chip), addr: i_req_addr, data: i_req_data};
  assign w_pop      = (state_q == S_IDLE) && !w_empty;

  opll_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_req   (w_push_req),
    .i_pop   (w_pop),
    .i_flush (i_flush),
    .o_head  (w_head),
    .o_level (w_level),
    .o_empty (w_empty)
  );

  assign w_head_idx = w_head.chip[CHIP_W-1:0];
  assign w_head_ok  = (int'(w_head.chip) < N_CHIPS);
  assign w_skip     = SKIP_SAME_ADDR && trk_valid_q[w_head_idx] &&
                      (trk_addr_q[w_head_idx] == w_head.addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_idx_q   <= '0;
      cur_addr_q  <= '0;
      cur_data_q  <= '0;
      cnt_q       <= '0;
      trk_valid_q <= '0;
      trk_addr_q  <= '0;
      cs_n_q      <= '1;
      wr_n_q      <= 1'b1;
      a0_q        <= 1'b0;
      d_q         <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // An out-of-range chip index is popped and silently discarded.
          if (!w_empty && w_head_ok) begin
            cur_idx_q  <= w_head_idx;
            cur_addr_q <= w_head.addr;
            cur_data_q <= w_head.data;
            cs_n_q     <= sel_n(w_head_idx);
            if (w_skip) begin
              state_q <= S_D_SETUP;
              a0_q    <= 1'b1;
              d_q     <= w_head.data;
            end else begin
              state_q <= S_A_SETUP;
              a0_q    <= 1'b0;
              d_q     <= w_head.addr;
            end
          end
        end
        S_A_SETUP: begin
          state_q <= S_A_STROBE;
          wr_n_q  <= 1'b0;
          cnt_q   <= CNT_STROBE;
        end
        S_A_STROBE: begin
          if (cnt_q == '0) begin
            state_q <= S_A_HOLD;
            wr_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_A_HOLD: begin
          trk_valid_q[cur_idx_q] <= 1'b1;
          trk_addr_q[cur_idx_q]  <= cur_addr_q;
          if (A_WAIT_LEN > 0) begin
            state_q <= S_A_WAIT;
            cs_n_q  <= '1;
            cnt_q   <= CNT_AWAIT;
          end else begin
            state_q <= S_D_SETUP;
            a0_q    <= 1'b1;
            d_q     <= cur_data_q;
          end
        end
        S_A_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= S_D_SETUP;
            cs_n_q  <= sel_n(cur_idx_q);
            a0_q    <= 1'b1;
            d_q     <= cur_data_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_D_SETUP: begin
          state_q <= S_D_STROBE;
          wr_n_q  <= 1'b0;
          cnt_q   <= CNT_STROBE;
        end
        S_D_STROBE: begin
          if (cnt_q == '0) begin
            state_q <= S_D_HOLD;
            wr_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_D_HOLD: begin
          cs_n_q <= '1;
          if (D_WAIT_LEN > 0) begin
            state_q <= S_D_WAIT;
            cnt_q   <= CNT_DWAIT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_D_WAIT: begin
          if (cnt_q == '0) state_q <= S_IDLE;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready = w_ready;
  assign o_CS_n      = cs_n_q;
  assign o_WR_n      = wr_n_q;
  assign o_A0        = a0_q;
  assign o_D         = d_q;
  assign o_busy      = (state_q != S_IDLE) || (w_level != '0);
  assign o_level     = w_level;

endmodule
`default_nettype wire

// File: tb/tb_opll_bus_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_opll_bus_write_sequencer
// Description : Self-checking bench for opll_bus_write_sequencer (2 chips,
//               default timing). A timeline model predicts every bus output
//               each cycle; directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opll_bus_write_sequencer;

  localparam int NC    = 2;
  localparam int DEPTH = 8;
  localparam int WP    = 2;
  localparam int AW    = 12;
  localparam int DW    = 84;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_req_valid = 1'b0;
  logic [0:0] i_req_chip = '0;
  logic [7:0] i_req_addr = '0;
  logic [7:0] i_req_data = '0;
  logic       i_flush = 1'b0;
  logic       o_req_ready;
  logic [1:0] o_CS_n;
  logic       o_WR_n;
  logic       o_A0;
  logic [7:0] o_D;
  logic       o_busy;
  logic [3:0] o_level;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  opll_bus_write_sequencer #(
    .N_CHIPS(NC), .FIFO_DEPTH(DEPTH), .WR_PULSE(WP),
    .ADDR_WAIT(AW), .DATA_WAIT(DW), .SKIP_SAME_ADDR(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_chip(i_req_chip), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .i_flush(i_flush),
    .o_CS_n(o_CS_n), .o_WR_n(o_WR_n), .o_A0(o_A0), .o_D(o_D),
    .o_busy(o_busy), .o_level(o_level)
  );

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- timeline model ----------------
  typedef struct { int chip; int addr; int data; } mreq_t;
  mreq_t      mq[$];
  mreq_t      m_cur;
  bit         m_active = 0;
  bit         m_skip = 0;
  bit         m_push;
  int         m_off = 0, m_base = 0, m_period = 0, m_r;
  bit         trk_v[NC];
  int         trk_a[NC];
  logic [1:0] e_cs = 2'b11;
  logic       e_wr = 1'b1, e_a0 = 1'b0;
  logic [7:0] e_d = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete();
      m_active = 0;
      for (int i = 0; i < NC; i++) begin trk_v[i] = 0; trk_a[i] = 0; end
      e_cs = 2'b11; e_wr = 1'b1; e_a0 = 1'b0; e_d = '0;
    end else begin
      m_push = i_req_valid && (mq.size() != DEPTH);
      if (m_active) begin
        m_off++;
        if (m_off == m_period) m_active = 0;
      end else if (mq.size() > 0) begin
        m_cur  = mq.pop_front();
        m_skip = trk_v[m_cur.chip] && (trk_a[m_cur.chip] == m_cur.addr);
        if (!m_skip) begin trk_v[m_cur.chip] = 1; trk_a[m_cur.chip] = m_cur.addr; end
        // Address phase plus its wait spans WP+AW cycles; data phase follows.
        m_base   = m_skip ? 0 : WP + AW;
        m_period = m_base + WP + DW + 2;
        m_active = 1;
        m_off    = 1;
      end
      if (i_flush) mq.delete();
      else if (m_push) mq.push_back('{int'(i_req_chip), int'(i_req_addr), int'(i_req_data)});
      e_cs = 2'b11;
      e_wr = 1'b1;
      if (m_active) begin
        if (!m_skip && m_off <= WP + AW) begin
          m_r = m_off; e_a0 = 1'b0; e_d = m_cur.addr[7:0];
        end else begin
          m_r = m_off - m_base; e_a0 = 1'b1; e_d = m_cur.data[7:0];
        end
        if (m_r <= WP + 2) e_cs[m_cur.chip] = 1'b0;
        if (m_r >= 2 && m_r <= WP + 1) e_wr = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    check("CS_n",  o_CS_n, e_cs);
    check("WR_n",  o_WR_n, e_wr);
    check("A0",    o_A0, e_a0);
    check("D",     o_D, e_d);
    check("level", o_level, mq.size());
    check("ready", o_req_ready, mq.size() != DEPTH);
    check("busy",  o_busy, m_active || mq.size() > 0);
  end

  // ---------------- bus event log ----------------
  int lg_a0[$], lg_d[$], lg_cs[$], lg_fall[$], lg_rise[$], lg_run0[$], lg_idle[$];
  bit p_wr = 1, p_busy = 0;
  int run0 = 0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      p_wr = 1; p_busy = 0; run0 = 0;
    end else begin
      if (p_wr && !o_WR_n) begin
        lg_a0.push_back(o_A0); lg_d.push_back(o_D);
        lg_cs.push_back(o_CS_n); lg_fall.push_back(cyc);
      end
      if (!p_wr && o_WR_n) lg_rise.push_back(cyc);
      if (!o_CS_n[0]) run0++;
      else if (run0 > 0) begin lg_run0.push_back(run0); run0 = 0; end
      if (p_busy && !o_busy) lg_idle.push_back(cyc);
      p_wr = o_WR_n; p_busy = o_busy;
    end
  end

  task automatic clear_log();
    lg_a0.delete(); lg_d.delete(); lg_cs.delete(); lg_fall.delete();
    lg_rise.delete(); lg_run0.delete(); lg_idle.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input int ch, input int ad, input int da);
    bit acc;
    int k;
    i_req_valid = 1'b1;
    i_req_chip  = ch[0:0];
    i_req_addr  = ad[7:0];
    i_req_data  = da[7:0];
    k = 0;
    acc = 0;
    while (!acc && k < 100) begin
      acc = o_req_ready;
      @(posedge clk); #1;
      k++;
    end
    i_req_valid = 1'b0;
    if (!acc) check("push accepted", 0, 1);
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int k;
    k = 0;
    while (o_busy && k < maxc) begin @(negedge clk); k++; end
    check({nm, " drained"}, o_busy, 0);
    @(negedge clk); @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic wait_strobe(input bit a0, input int maxc, input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (!(!o_WR_n && o_A0 == a0) && k < maxc) begin @(negedge clk); k++; end
    check({nm, " strobe seen"}, (!o_WR_n && o_A0 == a0), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // ---- reset ----
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst CS_n", o_CS_n, 2'b11);
    check("rst WR_n", o_WR_n, 1);
    check("rst A0", o_A0, 0);
    check("rst D", o_D, 0);
    check("rst level", o_level, 0);
    check("rst busy", o_busy, 0);
    check("rst ready", o_req_ready, 1);

    // ---- 1: single write, default timing ----
    clear_log();
    push(0, 8'h10, 8'h55);
    wait_idle(400, "t1");
    check("t1 strobes", lg_fall.size(), 2);
    if (lg_fall.size() == 2 && lg_rise.size() == 2 && lg_run0.size() == 2 && lg_idle.size() == 1) begin
      check("t1 addr A0", lg_a0[0], 0);
      check("t1 addr D", lg_d[0], 8'h10);
      check("t1 addr CS", lg_cs[0], 2'b10);
      check("t1 addr CS low cycles", lg_run0[0], 4);
      check("t1 WR low cycles", lg_rise[0] - lg_fall[0], 2);
      check("t1 addr rise to data fall", lg_fall[1] - lg_rise[0], 12);
      check("t1 data A0", lg_a0[1], 1);
      check("t1 data D", lg_d[1], 8'h55);
      check("t1 data CS low cycles", lg_run0[1], 4);
      check("t1 data rise to idle", lg_idle[0] - lg_rise[1], 84);
    end else check("t1 log shape", 0, 1);

    // ---- 2: nine back-to-back pushes into depth 8 ----
    clear_log();
    for (int i = 0; i < 9; i++) push(0, 8'h30 + i, 8'hA0 + i);
    check("t2 level full", o_level, 8);
    check("t2 ready low", o_req_ready, 0);
    wait_idle(2000, "t2");
    check("t2 strobes", lg_fall.size(), 18);
    if (lg_fall.size() == 18) begin
      for (int i = 0; i < 9; i++) begin
        check("t2 addr", lg_d[2*i], 8'h30 + i);
        check("t2 addr A0", lg_a0[2*i], 0);
        check("t2 data", lg_d[2*i+1], 8'hA0 + i);
      end
    end

    // ---- 3: same-address skip, tracked per chip ----
    clear_log();
    push(0, 8'h20, 8'h01);
    push(0, 8'h20, 8'h02);
    push(1, 8'h20, 8'h03);
    wait_idle(800, "t3");
    check("t3 strobes", lg_fall.size(), 5);
    if (lg_fall.size() == 5) begin
      check("t3 A0 seq", {lg_a0[0][0], lg_a0[1][0], lg_a0[2][0], lg_a0[3][0], lg_a0[4][0]}, 5'b01101);
      check("t3 D skip write", lg_d[2], 8'h02);
      check("t3 chip1 addr D", lg_d[3], 8'h20);
      check("t3 chip1 CS", lg_cs[3], 2'b01);
    end

    // ---- 4: alternating chips ----
    clear_log();
    for (int i = 0; i < 4; i++) push(i % 2, 8'h40 + i, 8'h11 + i);
    wait_idle(1000, "t4");
    check("t4 strobes", lg_fall.size(), 8);
    if (lg_fall.size() == 8) begin
      for (int i = 0; i < 4; i++) begin
        check("t4 addr CS", lg_cs[2*i], (i % 2 == 0) ? 2'b10 : 2'b01);
        check("t4 data CS", lg_cs[2*i+1], (i % 2 == 0) ? 2'b10 : 2'b01);
      end
    end

    // ---- 5: async reset during data strobe ----
    clear_log();
    push(0, 8'h44, 8'h99);
    wait_strobe(1'b1, 300, "t5");
    #3 rst = 1'b1;
    #1;
    check("t5 WR_n in reset", o_WR_n, 1);
    check("t5 CS_n in reset", o_CS_n, 2'b11);
    check("t5 D in reset", o_D, 0);
    @(posedge clk); #1 rst = 1'b0;
    check("t5 level after reset", o_level, 0);
    check("t5 busy after reset", o_busy, 0);
    clear_log();
    push(0, 8'h44, 8'h77);
    wait_idle(400, "t5");
    check("t5 strobes", lg_fall.size(), 2);
    if (lg_fall.size() == 2) begin
      check("t5 addr phase present", lg_a0[0], 0);
      check("t5 addr D", lg_d[0], 8'h44);
      check("t5 data D", lg_d[1], 8'h77);
    end

    // ---- 6: flush with entries queued behind an in-flight write ----
    clear_log();
    push(0, 8'h50, 8'h01);
    wait_strobe(1'b0, 50, "t6");
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) push(0, 8'h60 + i, 8'hB0 + i);
    check("t6 level queued", o_level, 5);
    i_flush = 1'b1; i_req_valid = 1'b1;
    i_req_chip = 1'b0; i_req_addr = 8'h70; i_req_data = 8'h70;
    @(posedge clk); #1;
    i_flush = 1'b0; i_req_valid = 1'b0;
    check("t6 level after flush", o_level, 0);
    check("t6 busy in flight", o_busy, 1);
    wait_idle(400, "t6");
    check("t6 strobes", lg_fall.size(), 2);
    if (lg_fall.size() == 2) check("t6 in-flight data", lg_d[1], 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
